// File: rtl/drink_vend_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// drink_pkg
// Shared types and helpers for the drink vending controller.
//   state_e     : controller FSM states
//   COIN_HALF   : coin_val encoding for a half-unit coin (worth 1 credit)
//   COIN_ONE    : coin_val encoding for a one-unit coin (worth 2 credits)
//   coin_value  : maps a coin_val bit to its credit value in half-units
// -----------------------------------------------------------------------------
package drink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_e;

  localparam logic COIN_HALF = 1'b0;
  localparam logic COIN_ONE  = 1'b1;

  function automatic logic [1:0] coin_value(input logic coin_val);
    return (coin_val == COIN_ONE) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/drink_vend_ctrl_if.sv
// -----------------------------------------------------------------------------
// drink_vend_if
// Bundles the coin, dispense and change handshakes plus the status outputs of
// the vending controller.
//   master : environment side (coin acceptor, mechanism, front panel)
//   slave  : controller side (drink_vend_ctrl)
// Signals:
//   coin_valid/coin_val/coin_ready : coin intake handshake
//   cancel, restock                : front-panel requests
//   disp_req/disp_ack              : dispense mechanism handshake
//   chg_req/chg_ack                : half-unit change ejector handshake
//   credit, stock, sold_out, sales_cnt : status
// -----------------------------------------------------------------------------
interface drink_vend_if #(
  parameter int STOCK_W  = 4,
  parameter int CREDIT_W = 3
);

  logic                coin_valid;
  logic                coin_val;
  logic                coin_ready;
  logic                cancel;
  logic                restock;
  logic                disp_req;
  logic                disp_ack;
  logic                chg_req;
  logic                chg_ack;
  logic [CREDIT_W-1:0] credit;
  logic [STOCK_W-1:0]  stock;
  logic                sold_out;
  logic [7:0]          sales_cnt;

  modport master (
    output coin_valid, coin_val, cancel, restock, disp_ack, chg_ack,
    input  coin_ready, disp_req, chg_req, credit, stock, sold_out, sales_cnt
  );

  modport slave (
    input  coin_valid, coin_val, cancel, restock, disp_ack, chg_ack,
    output coin_ready, disp_req, chg_req, credit, stock, sold_out, sales_cnt
  );

endinterface

// File: rtl/drink_stock_cnt.sv
// -----------------------------------------------------------------------------
// drink_stock_cnt
// Remaining-drink counter for one dispense channel.
//   clk      : clock
//   reset    : synchronous active-low reset, loads STOCK_INIT
//   load     : reload to STOCK_INIT (controller qualifies with IDLE)
//   dec      : one drink dispensed (controller qualifies with VEND ack)
//   stock    : current count
//   sold_out : stock == 0
// -----------------------------------------------------------------------------
module drink_stock_cnt
  import drink_pkg::*;
#(
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               dec,
  output logic [STOCK_W-1:0] stock,
  output logic               sold_out
);

  localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(STOCK_INIT);

  logic [STOCK_W-1:0] stock_q;
  logic [STOCK_W-1:0] stock_d;

  always_comb begin
    stock_d = stock_q;
    if (load) begin
      stock_d = INIT_VAL;
    end else if (dec && (stock_q != '0)) begin
      // The zero guard is belt-and-braces: VEND cannot be entered at zero.
      stock_d = stock_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stock_q <= INIT_VAL;
    end else begin
      stock_q <= stock_d;
    end
  end

  assign stock    = stock_q;
  assign sold_out = (stock_q == '0);

endmodule

// File: rtl/drink_vend_ctrl.sv
// -----------------------------------------------------------------------------
// drink_vend_ctrl
// Sequences one drink-dispense channel: collects coins into a credit register,
// requests a dispense once the price is reached, then pays back any remainder
// (or a cancelled credit) one half-unit coin at a time.
//   clk   : clock, all state changes on posedge
//   reset : synchronous active-low reset
//   bus   : drink_vend_if slave modport (coin, dispense and change handshakes
//           plus credit / stock / sold_out / sales_cnt status)
// -----------------------------------------------------------------------------
module drink_vend_ctrl
  import drink_pkg::*;
#(
  parameter int PRICE      = 3,
  parameter int STOCK_INIT = 8,
  parameter int STOCK_W    = 4,
  parameter int CREDIT_W   = 3
) (
  input  logic         clk,
  input  logic         reset,
  drink_vend_if.slave  bus
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [7:0]          sales_q, sales_d;
  logic                disp_req_q, disp_req_d;
  logic                chg_req_q, chg_req_d;

  logic                sold_out;
  logic [STOCK_W-1:0]  stock;
  logic                coin_ready;
  logic                coin_take;
  logic                vend_done;
  logic                stock_load;
  logic [CREDIT_W-1:0] credit_sum;
  logic [CREDIT_W-1:0] remainder;

  // Intake is open only while collecting and never on a cancel cycle, so a
  // coin offered together with cancel is left with the acceptor.
  assign coin_ready = ((state_q == ST_IDLE) || (state_q == ST_COLLECT))
                      && !sold_out && !bus.cancel;
  assign coin_take  = bus.coin_valid && coin_ready;
  assign vend_done  = (state_q == ST_VEND) && bus.disp_ack;
  assign stock_load = (state_q == ST_IDLE) && bus.restock;

  // Credit below PRICE plus at most 2 never exceeds PRICE+1, which fits.
  assign credit_sum = credit_q + CREDIT_W'(coin_value(bus.coin_val));
  assign remainder  = credit_q - PRICE_C;

  drink_stock_cnt #(
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT)
  ) u_stock (
    .clk      (clk),
    .reset    (reset),
    .load     (stock_load),
    .dec      (vend_done),
    .stock    (stock),
    .sold_out (sold_out)
  );

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    sales_d  = sales_q;

    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (coin_take) begin
          credit_d = credit_sum;
          state_d  = (credit_sum >= PRICE_C) ? ST_VEND : ST_COLLECT;
        end else if ((state_q == ST_COLLECT) && bus.cancel) begin
          // Full refund of whatever has been inserted so far.
          state_d = ST_CHANGE;
        end
      end
      ST_VEND: begin
        if (bus.disp_ack) begin
          credit_d = remainder;
          sales_d  = sales_q + 8'd1;
          state_d  = (remainder != '0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (bus.chg_ack) begin
          credit_d = credit_q - ONE_C;
          state_d  = (credit_q == ONE_C) ? ST_IDLE : ST_CHANGE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Requests are registered from the next state so they rise together with
    // the state entry and drop the cycle after the final ack.
    disp_req_d = (state_d == ST_VEND);
    chg_req_d  = (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      sales_q    <= '0;
      disp_req_q <= 1'b0;
      chg_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      sales_q    <= sales_d;
      disp_req_q <= disp_req_d;
      chg_req_q  <= chg_req_d;
    end
  end

  assign bus.coin_ready = coin_ready;
  assign bus.disp_req   = disp_req_q;
  assign bus.chg_req    = chg_req_q;
  assign bus.credit     = credit_q;
  assign bus.stock      = stock;
  assign bus.sold_out   = sold_out;
  assign bus.sales_cnt  = sales_q;

endmodule

// File: tb/tb_drink_vend_ctrl.sv
// -----------------------------------------------------------------------------
// tb_drink_vend_ctrl
// Directed bench for drink_vend_ctrl with a behavioural model (credit, stock,
// sales and two "owed" flags) checked on every negedge, plus literal checks
// pinning the expected values of the directed scenarios.
// -----------------------------------------------------------------------------
module tb_drink_vend_ctrl;

  localparam int PRICE      = 3;
  localparam int STOCK_INIT = 8;
  localparam int STOCK_W    = 4;
  localparam int CREDIT_W   = 3;

  logic clk;
  logic reset;

  drink_vend_if #(.STOCK_W(STOCK_W), .CREDIT_W(CREDIT_W)) bus ();

  drink_vend_ctrl #(
    .PRICE      (PRICE),
    .STOCK_INIT (STOCK_INIT),
    .STOCK_W    (STOCK_W),
    .CREDIT_W   (CREDIT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_vend: a dispense is owed; m_refund: coins are owed back.
  int m_credit = 0;
  int m_stock  = STOCK_INIT;
  int m_sales  = 0;
  bit m_vend   = 1'b0;
  bit m_refund = 1'b0;

  always @(posedge clk) begin
    int c, s, n;
    bit v, r, rdy, was_idle;
    c = m_credit; s = m_stock; n = m_sales; v = m_vend; r = m_refund;
    if (!reset) begin
      c = 0; s = STOCK_INIT; n = 0; v = 1'b0; r = 1'b0;
    end else if (v) begin
      if (bus.disp_ack) begin
        c = c - PRICE; s = s - 1; n = (n + 1) % 256; v = 1'b0; r = (c > 0);
      end
    end else if (r) begin
      if (bus.chg_ack) begin
        c = c - 1; r = (c > 0);
      end
    end else begin
      rdy      = (s != 0) && !bus.cancel;
      was_idle = (c == 0);
      if (bus.coin_valid && rdy) begin
        c = c + (bus.coin_val ? 2 : 1);
        v = (c >= PRICE);
      end else if (bus.cancel && c > 0) begin
        r = 1'b1;
      end
      if (bus.restock && was_idle) s = STOCK_INIT;
    end
    m_credit <= c; m_stock <= s; m_sales <= n; m_vend <= v; m_refund <= r;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("credit",     32'(bus.credit),     32'(m_credit));
      check("stock",      32'(bus.stock),      32'(m_stock));
      check("sales_cnt",  32'(bus.sales_cnt),  32'(m_sales));
      check("sold_out",   32'(bus.sold_out),   32'(m_stock == 0));
      check("disp_req",   32'(bus.disp_req),   32'(m_vend));
      check("chg_req",    32'(bus.chg_req),    32'(m_refund));
      check("coin_ready", 32'(bus.coin_ready),
            32'(!m_vend && !m_refund && (m_stock != 0) && !bus.cancel));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Inputs change 2 time units after posedge and are held for one edge.
  task automatic clr();
    bus.coin_valid = 1'b0; bus.coin_val = 1'b0; bus.cancel = 1'b0;
    bus.restock = 1'b0; bus.disp_ack = 1'b0; bus.chg_ack = 1'b0;
    reset = 1'b1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #2;
    clr();
  endtask

  task automatic coin(input bit v);
    bus.coin_valid = 1'b1; bus.coin_val = v;
    edge_step();
  endtask

  task automatic ack_disp();
    bus.disp_ack = 1'b1;
    edge_step();
  endtask

  task automatic ack_chg();
    bus.chg_ack = 1'b1;
    edge_step();
  endtask

  task automatic do_restock();
    bus.restock = 1'b1;
    edge_step();
  endtask

  task automatic vend_pattern(input int p);
    case (p)
      0: begin coin(1'b0); coin(1'b1); ack_disp(); end
      1: begin coin(1'b1); coin(1'b1); ack_disp(); ack_chg(); end
      default: begin coin(1'b0); coin(1'b0); coin(1'b0); ack_disp(); end
    endcase
  endtask

  initial begin
    clr();
    reset = 1'b0;
    @(posedge clk);
    #2;
    clr();
    chk_en = 1'b1;

    // Reset state
    check("rst_credit", 32'(bus.credit), 0);
    check("rst_stock", 32'(bus.stock), 8);
    check("rst_sales", 32'(bus.sales_cnt), 0);
    check("rst_reqs", 32'({bus.disp_req, bus.chg_req, bus.sold_out}), 0);
    check("rst_coin_ready", 32'(bus.coin_ready), 1);

    // Three halves: exact price, no change
    coin(1'b0); check("h1_credit", 32'(bus.credit), 1);
    coin(1'b0); check("h2_credit", 32'(bus.credit), 2);
    coin(1'b0); check("h3_credit", 32'(bus.credit), 3);
    check("h3_disp_req", 32'(bus.disp_req), 1);
    check("h3_coin_ready", 32'(bus.coin_ready), 0);
    ack_disp();
    check("h_credit", 32'(bus.credit), 0);
    check("h_stock", 32'(bus.stock), 7);
    check("h_sales", 32'(bus.sales_cnt), 1);
    check("h_reqs", 32'({bus.disp_req, bus.chg_req}), 0);

    // Two ones: one half-unit of change
    coin(1'b1); check("o1_credit", 32'(bus.credit), 2);
    coin(1'b1); check("o2_credit", 32'(bus.credit), 4);
    check("o2_disp_req", 32'(bus.disp_req), 1);
    ack_disp();
    check("o_credit", 32'(bus.credit), 1);
    check("o_chg_req", 32'(bus.chg_req), 1);
    check("o_disp_req", 32'(bus.disp_req), 0);
    ack_chg();
    check("o_chg_done", 32'({bus.chg_req, bus.credit}), 0);
    check("o_coin_ready", 32'(bus.coin_ready), 1);

    // Half then cancel with a coin offered in the same cycle
    coin(1'b0);
    bus.cancel = 1'b1; bus.coin_valid = 1'b1; bus.coin_val = 1'b0;
    #1;
    check("cx_coin_ready", 32'(bus.coin_ready), 0);
    edge_step();
    check("cx_chg_req", 32'(bus.chg_req), 1);
    check("cx_credit", 32'(bus.credit), 1);
    ack_chg();
    check("cx_done", 32'({bus.chg_req, bus.credit}), 0);
    check("cx_stock", 32'(bus.stock), 6);
    check("cx_sales", 32'(bus.sales_cnt), 2);

    // Stray acks, cancel in IDLE, restock outside IDLE
    ack_disp(); ack_chg();
    bus.cancel = 1'b1; edge_step();
    check("stray_state", 32'({bus.credit, bus.disp_req, bus.chg_req}), 0);
    check("stray_sales", 32'(bus.sales_cnt), 2);
    coin(1'b0);
    do_restock();
    check("rs_collect_stock", 32'(bus.stock), 6);
    bus.cancel = 1'b1; edge_step();
    ack_chg();

    // Reset during VEND with credit 4, then a late ack
    coin(1'b1); coin(1'b1);
    check("rv_pre", 32'({bus.disp_req, bus.credit}), 32'({1'b1, 3'd4}));
    reset = 1'b0;
    @(posedge clk);
    #2;
    clr();
    check("rv_disp_req", 32'(bus.disp_req), 0);
    check("rv_credit", 32'(bus.credit), 0);
    check("rv_stock", 32'(bus.stock), 8);
    check("rv_sales", 32'(bus.sales_cnt), 0);
    check("rv_coin_ready", 32'(bus.coin_ready), 1);
    ack_disp();
    check("rv_late_ack", 32'({bus.sales_cnt, bus.credit}), 0);

    // 256 vends with restocks: sold-out behaviour and sales wrap
    for (int i = 0; i < 256; i++) begin
      if (i > 0 && (i % 8) == 0) begin
        if (i == 8) begin
          check("so_stock", 32'(bus.stock), 0);
          check("so_sold_out", 32'(bus.sold_out), 1);
          check("so_coin_ready", 32'(bus.coin_ready), 0);
          coin(1'b1);
          check("so_coin_refused", 32'(bus.credit), 0);
        end
        do_restock();
        if (i == 8) begin
          check("rs_stock", 32'(bus.stock), 8);
          check("rs_sold_out", 32'(bus.sold_out), 0);
          check("rs_coin_ready", 32'(bus.coin_ready), 1);
        end
      end
      vend_pattern(i % 3);
      if (i == 254) check("sales_255", 32'(bus.sales_cnt), 255);
    end
    check("sales_wrap", 32'(bus.sales_cnt), 0);
    check("wrap_stock", 32'(bus.stock), 0);

    edge_step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
